// File: rtl/pc_update_ctrl.sv
// PC-update sequencer for the multicycle CPU: steers the PC source mux, PC/EPC/MDR
// load enables and runs the multi-cycle exception-vector fetch.
module pc_update_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int VEC_OVF = 255,
    parameter int VEC_OPC = 254,
    parameter int VEC_DIV = 253
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic        zero,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    output logic [2:0]  pc_src,
    output logic        pc_write,
    output logic        epc_write,
    output logic        mem_rd,
    output logic [31:0] vec_addr,
    output logic        mdr_write,
    output logic [1:0]  cause,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPD,
        S_EXC_EPC,
        S_EXC_RD,
        S_EXC_MDR,
        S_EXC_LOAD
    } state_t;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_J    = 3'b011;
    localparam logic [2:0] OP_JR   = 3'b100;
    localparam logic [2:0] OP_ERET = 3'b101;

    localparam logic [2:0] SRC_ALU    = 3'b000;
    localparam logic [2:0] SRC_EPC    = 3'b001;
    localparam logic [2:0] SRC_ALUOUT = 3'b010;
    localparam logic [2:0] SRC_JUMP   = 3'b011;
    localparam logic [2:0] SRC_MDR    = 3'b100;

    localparam logic [1:0] CAUSE_OVF = 2'b00;
    localparam logic [1:0] CAUSE_OPC = 2'b01;
    localparam logic [1:0] CAUSE_DIV = 2'b10;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_op;
    logic [2:0]       w_op_next;
    logic             r_zero;
    logic             w_zero_next;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause_next;
    logic             r_pending;
    logic             w_pending_next;
    logic [1:0]       r_pend_cause;
    logic [1:0]       w_pend_cause_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_exc_cause;

    // Reserved cause code folds onto overflow.
    assign w_exc_cause = (exc_cause == 2'b11) ? CAUSE_OVF : exc_cause;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= OP_SEQ;
            r_zero       <= 1'b0;
            r_cause      <= CAUSE_OVF;
            r_pending    <= 1'b0;
            r_pend_cause <= CAUSE_OVF;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_op         <= w_op_next;
            r_zero       <= w_zero_next;
            r_cause      <= w_cause_next;
            r_pending    <= w_pending_next;
            r_pend_cause <= w_pend_cause_next;
            r_cnt        <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_op_next         = r_op;
        w_zero_next       = r_zero;
        w_cause_next      = r_cause;
        w_pending_next    = r_pending;
        w_pend_cause_next = r_pend_cause;
        w_cnt_next        = r_cnt;

        case (r_state)
            S_IDLE: begin
                // A fresh exception carries the newest cause, so it beats a pending one.
                if (exc_req || r_pending) begin
                    w_state_next   = S_EXC_EPC;
                    w_cause_next   = exc_req ? w_exc_cause : r_pend_cause;
                    w_pending_next = 1'b0;
                end else if (req) begin
                    if (op[2:1] == 2'b11) begin
                        w_state_next = S_EXC_EPC;
                        w_cause_next = CAUSE_OPC;
                    end else begin
                        w_state_next = S_UPD;
                        w_op_next    = op;
                        w_zero_next  = zero;
                    end
                end
            end
            S_UPD:      w_state_next = S_IDLE;
            S_EXC_EPC: begin
                w_state_next = S_EXC_RD;
                w_cnt_next   = CNT_W'(MEM_LAT - 1);
            end
            S_EXC_RD: begin
                if (r_cnt == '0) begin
                    w_state_next = S_EXC_MDR;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_EXC_MDR:  w_state_next = S_EXC_LOAD;
            S_EXC_LOAD: w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase

        if ((r_state != S_IDLE) && exc_req) begin
            w_pending_next    = 1'b1;
            w_pend_cause_next = w_exc_cause;
        end
    end

    always_comb begin
        pc_src    = SRC_ALU;
        pc_write  = 1'b0;
        epc_write = 1'b0;
        mem_rd    = 1'b0;
        vec_addr  = 32'd0;
        mdr_write = 1'b0;
        done      = 1'b0;
        busy      = (r_state != S_IDLE);
        cause     = r_cause;

        case (r_state)
            S_UPD: begin
                done = 1'b1;
                case (r_op)
                    OP_SEQ: begin
                        pc_src   = SRC_ALU;
                        pc_write = 1'b1;
                    end
                    OP_BEQ: begin
                        pc_src   = SRC_ALUOUT;
                        pc_write = r_zero;
                    end
                    OP_BNE: begin
                        pc_src   = SRC_ALUOUT;
                        pc_write = ~r_zero;
                    end
                    OP_J: begin
                        pc_src   = SRC_JUMP;
                        pc_write = 1'b1;
                    end
                    OP_JR: begin
                        pc_src   = SRC_ALUOUT;
                        pc_write = 1'b1;
                    end
                    OP_ERET: begin
                        pc_src   = SRC_EPC;
                        pc_write = 1'b1;
                    end
                    default: pc_write = 1'b0;
                endcase
            end
            S_EXC_EPC: epc_write = 1'b1;
            S_EXC_RD: begin
                mem_rd = 1'b1;
                case (r_cause)
                    CAUSE_OPC: vec_addr = 32'(VEC_OPC);
                    CAUSE_DIV: vec_addr = 32'(VEC_DIV);
                    default:   vec_addr = 32'(VEC_OVF);
                endcase
            end
            S_EXC_MDR: mdr_write = 1'b1;
            S_EXC_LOAD: begin
                pc_src   = SRC_MDR;
                pc_write = 1'b1;
                done     = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Scoreboard bench for pc_update_ctrl: a transaction-level model queues the expected
// per-cycle output records, and an independent monitor pops and compares them.
module tb_pc_update_ctrl;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic        zero;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [2:0]  pc_src;
    logic        pc_write;
    logic        epc_write;
    logic        mem_rd;
    logic [31:0] vec_addr;
    logic        mdr_write;
    logic [1:0]  cause;
    logic        busy;
    logic        done;

    pc_update_ctrl #(
        .MEM_LAT(MEM_LAT),
        .VEC_OVF(255),
        .VEC_OPC(254),
        .VEC_DIV(253)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .zero      (zero),
        .exc_req   (exc_req),
        .exc_cause (exc_cause),
        .pc_src    (pc_src),
        .pc_write  (pc_write),
        .epc_write (epc_write),
        .mem_rd    (mem_rd),
        .vec_addr  (vec_addr),
        .mdr_write (mdr_write),
        .cause     (cause),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  pc_src;
        logic        pc_write;
        logic        epc_write;
        logic        mem_rd;
        logic [31:0] vec_addr;
        logic        mdr_write;
        logic [1:0]  cause;
        logic        done;
    } rec_t;

    rec_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;
    logic       exp_busy = 1'b0;
    int         mdl_left = 0;
    logic       mdl_pend = 1'b0;
    logic [1:0] mdl_pcause = 2'b00;
    logic [1:0] mdl_cause  = 2'b00;

    function automatic logic [31:0] vec_of(input logic [1:0] c);
        case (c)
            2'd1:    return 32'd254;
            2'd2:    return 32'd253;
            default: return 32'd255;
        endcase
    endfunction

    // Single-cycle update outcome, straight from the op table.
    function automatic rec_t upd_rec(input logic [2:0] o, input logic z, input logic [1:0] c);
        rec_t r;
        r = '0;
        r.done  = 1'b1;
        r.cause = c;
        case (o)
            3'd0: r.pc_write = 1'b1;
            3'd1: begin r.pc_src = 3'd2; r.pc_write = z;  end
            3'd2: begin r.pc_src = 3'd2; r.pc_write = !z; end
            3'd3: begin r.pc_src = 3'd3; r.pc_write = 1'b1; end
            3'd4: begin r.pc_src = 3'd2; r.pc_write = 1'b1; end
            default: begin r.pc_src = 3'd1; r.pc_write = 1'b1; end
        endcase
        return r;
    endfunction

    task automatic push_exc(input logic [1:0] c);
        rec_t r;
        mdl_cause = c;
        r = '0; r.cause = c; r.epc_write = 1'b1;
        exp_q.push_back(r);
        for (int k = 0; k < MEM_LAT; k++) begin
            r = '0; r.cause = c; r.mem_rd = 1'b1; r.vec_addr = vec_of(c);
            exp_q.push_back(r);
        end
        r = '0; r.cause = c; r.mdr_write = 1'b1;
        exp_q.push_back(r);
        r = '0; r.cause = c; r.pc_src = 3'd4; r.pc_write = 1'b1; r.done = 1'b1;
        exp_q.push_back(r);
        mdl_left = MEM_LAT + 3;
    endtask

    task automatic model_step(input logic r, input logic [2:0] o, input logic z,
                              input logic e, input logic [1:0] c);
        logic [1:0] nc;
        nc = (c == 2'd3) ? 2'd0 : c;
        if (mdl_left == 0) begin
            if (e || mdl_pend) begin
                push_exc(e ? nc : mdl_pcause);
                mdl_pend = 1'b0;
            end else if (r) begin
                if (o >= 3'd6) begin
                    push_exc(2'd1);
                end else begin
                    exp_q.push_back(upd_rec(o, z, mdl_cause));
                    mdl_left = 1;
                end
            end
        end else begin
            if (e) begin
                mdl_pend   = 1'b1;
                mdl_pcause = nc;
            end
            mdl_left--;
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] o, input logic z,
                         input logic e, input logic [1:0] c);
        @(posedge clk);
        #2;
        exp_busy  = (mdl_left > 0);
        req       = r;
        op        = o;
        zero      = z;
        exc_req   = e;
        exc_cause = c;
        model_step(r, o, z, e, c);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            rec_t act;
            rec_t e;
            act = {pc_src, pc_write, epc_write, mem_rd, vec_addr, mdr_write, cause, done};
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy @%0t: got %b expected %b", $time, busy, exp_busy);
            end
            if ((pc_write | epc_write | mem_rd | mdr_write | done) !== 1'b0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output @%0t: got %h expected no activity", $time, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL output @%0t: got src=%0d pcw=%b epcw=%b rd=%b va=%0d mdrw=%b cause=%0d done=%b expected src=%0d pcw=%b epcw=%b rd=%b va=%0d mdrw=%b cause=%0d done=%b",
                                 $time, act.pc_src, act.pc_write, act.epc_write, act.mem_rd,
                                 act.vec_addr, act.mdr_write, act.cause, act.done,
                                 e.pc_src, e.pc_write, e.epc_write, e.mem_rd,
                                 e.vec_addr, e.mdr_write, e.cause, e.done);
                    end else if (done === 1'b1) begin
                        $display("txn @%0t: done pc_src=%0d pc_write=%b cause=%0d", $time, pc_src, pc_write, cause);
                    end
                end
            end
        end
    end

    logic [42:0] all_outs;
    assign all_outs = {pc_src, pc_write, epc_write, mem_rd, vec_addr, mdr_write, cause, busy, done};

    initial begin
        reset = 1'b1; req = 1'b0; op = 3'd0; zero = 1'b0; exc_req = 1'b0; exc_cause = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_held_outputs", 64'(all_outs), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_release_outputs", 64'(all_outs), 64'd0);
        mon_en = 1'b1;

        // Directed scenarios through the scoreboard.
        drive(1'b1, 3'd1, 1'b1, 1'b0, 2'd0); idle(1);    // BEQ taken
        drive(1'b1, 3'd1, 1'b0, 1'b0, 2'd0); idle(1);    // BEQ not taken
        drive(1'b1, 3'd3, 1'b0, 1'b0, 2'd0); idle(1);    // J
        drive(1'b1, 3'd5, 1'b0, 1'b0, 2'd0); idle(1);    // ERET
        drive(1'b1, 3'd2, 1'b0, 1'b0, 2'd0); idle(1);    // BNE taken
        drive(1'b1, 3'd4, 1'b1, 1'b0, 2'd0); idle(1);    // JR
        drive(1'b0, 3'd0, 1'b0, 1'b1, 2'd0); idle(6);    // overflow exception
        drive(1'b1, 3'd6, 1'b0, 1'b0, 2'd0); idle(6);    // illegal op
        drive(1'b1, 3'd0, 1'b0, 1'b0, 2'd0);             // SEQ
        drive(1'b0, 3'd0, 1'b0, 1'b1, 2'd2);             // exception during UPD -> pending
        idle(8);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 2'd3); idle(6);    // reserved cause
        drive(1'b0, 3'd0, 1'b0, 1'b1, 2'd1);             // exc with req ignored while busy
        drive(1'b1, 3'd3, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 2'd2);             // pending, then overwritten
        drive(1'b0, 3'd0, 1'b0, 1'b1, 2'd0);
        idle(12);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 60 && (mdl_left != 0 || mdl_pend); i++) idle(1);
        idle(2);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        // Reset in the middle of the vector read, with an exception pending.
        drive(1'b0, 3'd0, 1'b0, 1'b1, 2'd0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 2'd2);
        @(posedge clk);
        #2;
        exc_req = 1'b0;
        check("rd_state_mem_rd", 64'(mem_rd), 64'd1);
        check("rd_state_vec_addr", 64'(vec_addr), 64'd255);
        reset = 1'b1;
        #1;
        check("reset_mid_seq_outputs", 64'(all_outs), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mdl_left = 0; mdl_pend = 1'b0; mdl_cause = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_idle_no_pending", 64'(all_outs), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
